// File: rtl/strided_buffer_reader.sv
// Purpose : walks a column-banked frame buffer as N_BUF_X-wide windows and emits one window beat per step.
// Latency : bank data arrives 1 cycle after rden; a beat is presented on dout the cycle after that.
// Backpres: 2-entry output FIFO; rden is issued only while FIFO entries plus in-flight reads < 2.
//
// Ports   : clk/rstn (sync, active-low) ; dshape {w,h,c} + start begin a frame ; clr aborts to IDLE
//           wr_cols  columns already written (only consulted with STRIDED_RD_FLOWCTL_EN defined)
//           rden/rdaddr/di  bank read port (bank b address/data at slice b)
//           dout/dout_valid/dout_ready/dout_last  window beat stream ; busy/done status
// Macro   : STRIDED_RD_FLOWCTL_EN -- when defined, WAIT_COL holds until ox+N_BUF_X <= wr_cols.
module strided_buffer_reader #(
    parameter int N_BUF_X    = 5,
    parameter int DATA_WIDTH = 64,
    parameter int B_BUF_ADDR = 10,
    parameter int B_COORD    = 8,
    parameter int B_DSHAPE   = 48
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [B_DSHAPE-1:0]              dshape,
    input  logic                             start,
    input  logic                             clr,
    input  logic [B_COORD-1:0]               wr_cols,
    output logic                             rden,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]    rdaddr,
    input  logic [DATA_WIDTH*N_BUF_X-1:0]    di,
    output logic [DATA_WIDTH*N_BUF_X-1:0]    dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic                             dout_last,
    output logic                             busy,
    output logic                             done
);

    localparam int ROT_W  = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
    localparam int BEAT_W = DATA_WIDTH * N_BUF_X;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_COL,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;

    // frame geometry captured at start
    logic [B_COORD-1:0]      last_ox_q, last_ox_d;
    logic [B_COORD-1:0]      last_y_q, last_y_d;
    logic [B_COORD-1:0]      last_cw_q, last_cw_d;
    logic [B_BUF_ADDR-1:0]   colsz_q, colsz_d;
    logic                    empty_q, empty_d;

    // iteration state
    logic [B_COORD-1:0]      ox_q, ox_d;
    logic [B_COORD-1:0]      y_q, y_d;
    logic [B_COORD-1:0]      cw_q, cw_d;
    // off = y*ncw + cw, kept as a running count since it steps by one per read
    logic [B_BUF_ADDR-1:0]   off_q, off_d;
    logic [B_BUF_ADDR-1:0]   base_q [N_BUF_X];
    logic [B_BUF_ADDR-1:0]   base_d [N_BUF_X];
    logic [ROT_W-1:0]        rot_q, rot_d;

    // the read issued last cycle, whose data is on di now
    logic                    inf_vld_q, inf_vld_d;
    logic [ROT_W-1:0]        inf_rot_q, inf_rot_d;
    logic                    inf_last_q, inf_last_d;

    // 2-entry output FIFO
    logic [BEAT_W-1:0]       fifo_dat_q [2];
    logic [BEAT_W-1:0]       fifo_dat_d [2];
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;

    logic [15:0]             w_in, h_in, c_in;
    logic [B_COORD-1:0]      ncw_in;
    logic [BEAT_W-1:0]       rot_beat;
    logic                    col_ok;
    logic                    push, pop;
    logic                    unused_in;

    assign w_in   = dshape[47:32];
    assign h_in   = dshape[31:16];
    assign c_in   = dshape[15:0];
    assign ncw_in = B_COORD'(c_in >> 6);

    // low channel bits and (without flow control) wr_cols are intentionally not consumed
    assign unused_in = ^{dshape, wr_cols};

`ifdef STRIDED_RD_FLOWCTL_EN
    assign col_ok = ({1'b0, ox_q} + (B_COORD+1)'(N_BUF_X)) <= {1'b0, wr_cols};
`else
    assign col_ok = 1'b1;
`endif

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign dout_valid = (cnt_q != 2'd0);
    assign dout       = dout_valid ? fifo_dat_q[rd_ptr_q] : '0;
    assign dout_last  = dout_valid & fifo_last_q[rd_ptr_q];

    // in-flight read counts against FIFO space so the FIFO can never overflow
    assign rden = (state_q == S_READ) && ((cnt_q + {1'b0, inf_vld_q}) < 2'd2) && !clr;

    assign push = inf_vld_q;
    assign pop  = dout_valid && dout_ready;

    always_comb begin
        rdaddr = '0;
        for (int b = 0; b < N_BUF_X; b++) begin
            rdaddr[b*B_BUF_ADDR +: B_BUF_ADDR] = base_q[b] + off_q;
        end
    end

    // slot k takes bank (rot+k) mod N, rot being the value current when the read issued
    always_comb begin
        rot_beat = '0;
        for (int k = 0; k < N_BUF_X; k++) begin
            rot_beat[k*DATA_WIDTH +: DATA_WIDTH] =
                di[((int'(inf_rot_q) + k) % N_BUF_X)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        last_ox_d   = last_ox_q;
        last_y_d    = last_y_q;
        last_cw_d   = last_cw_q;
        colsz_d     = colsz_q;
        empty_d     = empty_q;
        ox_d        = ox_q;
        y_d         = y_q;
        cw_d        = cw_q;
        off_d       = off_q;
        base_d      = base_q;
        rot_d       = rot_q;
        inf_vld_d   = rden;
        inf_rot_d   = rot_q;
        inf_last_d  = 1'b0;
        fifo_dat_d  = fifo_dat_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + 2'(push) - 2'(pop);

        if (push) begin
            fifo_dat_d[wr_ptr_q]  = rot_beat;
            fifo_last_d[wr_ptr_q] = inf_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT_COL;
                    empty_d   = (w_in < 16'(N_BUF_X)) || (h_in == 16'd0) || (ncw_in == '0);
                    last_ox_d = B_COORD'(w_in - 16'(N_BUF_X));
                    last_y_d  = B_COORD'(h_in - 16'd1);
                    last_cw_d = ncw_in - B_COORD'(1);
                    colsz_d   = B_BUF_ADDR'(32'(h_in) * 32'(ncw_in));
                    ox_d      = '0;
                    y_d       = '0;
                    cw_d      = '0;
                    off_d     = '0;
                    rot_d     = '0;
                    for (int b = 0; b < N_BUF_X; b++) begin
                        base_d[b] = '0;
                    end
                end
            end
            S_WAIT_COL: begin
                if (empty_q) begin
                    state_d = S_DONE;
                end else if (col_ok) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rden) begin
                    off_d = off_q + B_BUF_ADDR'(1);
                    if (cw_q != last_cw_q) begin
                        cw_d = cw_q + B_COORD'(1);
                    end else begin
                        cw_d = '0;
                        if (y_q != last_y_q) begin
                            y_d = y_q + B_COORD'(1);
                        end else begin
                            y_d   = '0;
                            off_d = '0;
                            if (ox_q == last_ox_q) begin
                                inf_last_d = 1'b1;
                                state_d    = S_DRAIN;
                            end else begin
                                // the bank that held column ox now serves column ox+N, one colsz further on
                                ox_d           = ox_q + B_COORD'(1);
                                base_d[rot_q]  = base_q[rot_q] + colsz_q;
                                rot_d          = (rot_q == ROT_W'(N_BUF_X-1)) ? '0 : rot_q + ROT_W'(1);
                                state_d        = S_WAIT_COL;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if ((cnt_q == 2'd0) && !inf_vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clr) begin
            state_d    = S_IDLE;
            ox_d       = '0;
            y_d        = '0;
            cw_d       = '0;
            off_d      = '0;
            rot_d      = '0;
            inf_vld_d  = 1'b0;
            inf_last_d = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            cnt_d      = 2'd0;
            for (int b = 0; b < N_BUF_X; b++) begin
                base_d[b] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            last_ox_q   <= '0;
            last_y_q    <= '0;
            last_cw_q   <= '0;
            colsz_q     <= '0;
            empty_q     <= 1'b0;
            ox_q        <= '0;
            y_q         <= '0;
            cw_q        <= '0;
            off_q       <= '0;
            rot_q       <= '0;
            inf_vld_q   <= 1'b0;
            inf_rot_q   <= '0;
            inf_last_q  <= 1'b0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            for (int b = 0; b < N_BUF_X; b++) begin
                base_q[b] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                fifo_dat_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            last_ox_q   <= last_ox_d;
            last_y_q    <= last_y_d;
            last_cw_q   <= last_cw_d;
            colsz_q     <= colsz_d;
            empty_q     <= empty_d;
            ox_q        <= ox_d;
            y_q         <= y_d;
            cw_q        <= cw_d;
            off_q       <= off_d;
            rot_q       <= rot_d;
            inf_vld_q   <= inf_vld_d;
            inf_rot_q   <= inf_rot_d;
            inf_last_q  <= inf_last_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            fifo_dat_q  <= fifo_dat_d;
        end
    end

endmodule

// File: tb/tb_strided_buffer_reader.sv
// Directed bench for strided_buffer_reader: bank memory model, expected-beat queue, protocol monitors.
module tb_strided_buffer_reader;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int BA = 4;
    localparam int BC = 8;
    localparam int BD = 48;
    localparam int BW = N * DW;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic            clr = 1'b0;
    logic            dout_ready = 1'b1;
    logic [BD-1:0]   dshape = '0;
    logic [BC-1:0]   wr_cols;
    logic            rden;
    logic [BA*N-1:0] rdaddr;
    logic [BW-1:0]   di = '0;
    logic [BW-1:0]   dout;
    logic            dout_valid, dout_last, busy, done;

    typedef struct {
        logic [BW-1:0] dat;
        logic          last;
    } beat_t;

    beat_t           exp_q[$];
    logic [BA*N-1:0] addr_log[$];
    beat_t           mon_e;

    int n_tests = 0, n_fail = 0;
    int beat_cnt = 0, issued = 0, accepted = 0;
    int hold_viol = 0, pend_viol = 0, done_seen = 0;
    bit chk_en = 1'b0, rdy_toggle = 1'b0, prev_stall = 1'b0;
    logic [BW-1:0] prev_dout = '0;

    strided_buffer_reader #(
        .N_BUF_X(N), .DATA_WIDTH(DW), .B_BUF_ADDR(BA), .B_COORD(BC), .B_DSHAPE(BD)
    ) dut (
        .clk(clk), .rstn(rstn), .dshape(dshape), .start(start), .clr(clr),
        .wr_cols(wr_cols), .rden(rden), .rdaddr(rdaddr), .di(di), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] bank_word(input int b, input int a);
        logic [3:0] bb;
        logic [7:0] aa;
        bb = 4'(b);
        aa = 8'(a);
        return {4'hA, bb, aa};
    endfunction

    // bank memory: one-cycle read latency, each word tagged with its bank and address
    always @(posedge clk) begin
        if (rden) begin
            for (int b = 0; b < N; b++) begin
                di[b*DW +: DW] <= bank_word(b, int'(rdaddr[b*BA +: BA]));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        dout_ready = rdy_toggle ? ~dout_ready : 1'b1;
    end

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_seen++;
            if (rden) begin
                if (issued - accepted >= 2) pend_viol++;
                issued++;
                addr_log.push_back(rdaddr);
            end
            if (prev_stall && (!dout_valid || dout != prev_dout)) hold_viol++;
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (dout_valid && dout_ready) begin
                accepted++;
                beat_cnt++;
                if (chk_en) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_dat", dout, mon_e.dat);
                        check("beat_last", dout_last, mon_e.last);
                    end
                end
            end
        end
    end

    // bank layout: column x lives in bank x%N at (x/N)*colsz + y*ncw + cw
    task automatic build_exp(input int w, input int h, input int c);
        int ncw, colsz, total, idx, x, a;
        beat_t e;
        exp_q.delete();
        ncw   = (c >> 6) & 255;
        colsz = (h * ncw) % (1 << BA);
        total = (w >= N) ? (w - N + 1) * h * ncw : 0;
        idx   = 0;
        for (int ox = 0; ox <= w - N; ox++) begin
            for (int y = 0; y < h; y++) begin
                for (int cw = 0; cw < ncw; cw++) begin
                    for (int k = 0; k < N; k++) begin
                        x = ox + k;
                        a = ((x / N) * colsz + y * ncw + cw) % (1 << BA);
                        e.dat[k*DW +: DW] = bank_word(x % N, a);
                    end
                    e.last = (idx == total - 1);
                    exp_q.push_back(e);
                    idx++;
                end
            end
        end
    endtask

    task automatic start_frame(input int w, input int h, input int c);
        build_exp(w, h, c);
        beat_cnt = 0;
        issued   = 0;
        accepted = 0;
        addr_log.delete();
        dshape = {16'(w), 16'(h), 16'(c)};
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int k = 0;
        while (!done && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic run_frame(input int w, input int h, input int c, input string tag, input int n_exp);
        start_frame(w, h, c);
        wait_done(tag, 3000);
        check({tag, "_beats"}, beat_cnt, n_exp);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int eb0[4] = '{0, 1, 2, 3};
        int eb1[4] = '{0, 1, 0, 1};
        int k;
        int seen;
        logic [BA*N-1:0] al;

`ifdef STRIDED_RD_FLOWCTL_EN
        wr_cols = 8'd255;
`else
        wr_cols = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", rden, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", dout_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // 6x2, one channel word: 4 beats, column 5 served by bank 0 at colsz=2
        chk_en = 1'b1;
        run_frame(6, 2, 64, "fa", 4);
        check("fa_nreads", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            al = (i < addr_log.size()) ? addr_log[i] : '1;
            check($sformatf("fa_addr%0d_b0", i), al[0 +: BA], eb0[i]);
            check($sformatf("fa_addr%0d_b1", i), al[BA +: BA], eb1[i]);
        end

        // same frame under 1010 ready pattern
        rdy_toggle = 1'b1;
        run_frame(6, 2, 64, "fa_tgl", 4);
        rdy_toggle = 1'b0;
        check("tgl_hold_viol", hold_viol, 0);
        check("tgl_pend_viol", pend_viol, 0);
        @(posedge clk); #1;

        // w < N: empty frame, done two cycles after start
        start_frame(4, 2, 64);
        check("zero_done_t1", done, 0);
        @(posedge clk); #1;
        check("zero_done_t2", done, 1);
        check("zero_busy_t2", busy, 1);
        @(posedge clk); #1;
        check("zero_done_t3", done, 0);
        check("zero_busy_t3", busy, 0);
        check("zero_beats", beat_cnt, 0);

        // abort on the second beat, then replay
        chk_en = 1'b0;
        start_frame(6, 2, 64);
        k = 0;
        while (!(dout_valid && beat_cnt == 1) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("clr_second_beat", dout_valid, 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_valid", dout_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_rden", rden, 0);
        chk_en = 1'b1;
        run_frame(6, 2, 64, "replay", 4);
        al = (addr_log.size() > 0) ? addr_log[0] : '1;
        check("replay_addr0", al, 0);

        // two channel words, 3 rows, 3 window positions: 18 beats
        run_frame(7, 3, 128, "f18", 18);

        // colsz=12 with 4-bit addresses: second bank round wraps
        run_frame(10, 4, 192, "wrap", 72);

`ifdef STRIDED_RD_FLOWCTL_EN
        wr_cols = 8'd4;
        start_frame(6, 2, 64);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rden) seen++;
        end
        check("fc_stall_rden", seen, 0);
        check("fc_stall_busy", busy, 1);
        wr_cols = 8'd5;
        k = 0;
        while (!rden && k < 4) begin
            @(posedge clk); #1;
            k++;
        end
        check("fc_resume", rden, 1);
        check("fc_resume_lat", (k <= 2), 1);
        wr_cols = 8'd255;
        wait_done("fc", 500);
        check("fc_beats", beat_cnt, 4);
`endif

        // reset mid-frame: frame abandoned, no done pulse
        chk_en = 1'b0;
        start_frame(7, 3, 128);
        repeat (4) begin
            @(posedge clk); #1;
        end
        done_seen = 0;
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy", busy, 0);
        check("mrst_valid", dout_valid, 0);
        check("mrst_rden", rden, 0);
        rstn = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("mrst_no_done", done_seen, 0);
        check("mrst_idle", busy, 0);

        check("all_hold_viol", hold_viol, 0);
        check("all_pend_viol", pend_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
